// File: rtl/osd_cmd_pkg.sv
// Command word carried from the batch table into the OSD writer queue.
package osd_cmd_pkg;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] addr;
        logic [15:0] data;
    } osd_cmd_t;

endpackage

// File: rtl/osd_batch_enqueuer_if.sv
// Load port, sequencing controls and command stream of the batch enqueuer.
interface osd_batch_enqueuer_if #(
    parameter int unsigned NUM_CMDS_MAX = 64
);
    localparam int unsigned AW = $clog2(NUM_CMDS_MAX);
    localparam int unsigned CW = $clog2(NUM_CMDS_MAX + 1);

    logic                  load_we;
    logic [AW-1:0]         load_addr;
    osd_cmd_pkg::osd_cmd_t load_data;
    logic [CW-1:0]         seq_count;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  load_err;
    logic                  cmd_valid;
    logic                  cmd_ready;
    osd_cmd_pkg::osd_cmd_t cmd_data;
    logic                  cmd_last;

    // Loader / init FSM side.
    modport master (
        output load_we, load_addr, load_data, seq_count, start, cmd_ready,
        input  busy, done, load_err, cmd_valid, cmd_data, cmd_last
    );

    // Enqueuer side.
    modport slave (
        input  load_we, load_addr, load_data, seq_count, start, cmd_ready,
        output busy, done, load_err, cmd_valid, cmd_data, cmd_last
    );

endinterface

// File: rtl/osd_batch_enqueuer.sv
// Command table plus replay sequencer: stores osd_cmd_t words and streams the
// first seq_count of them in address order on start, then pulses done.
module osd_batch_enqueuer #(
    parameter int unsigned NUM_CMDS_MAX = 64
) (
    input logic                 clk,
    input logic                 rst,
    osd_batch_enqueuer_if.slave bus
);
    import osd_cmd_pkg::*;

    localparam int unsigned AW = $clog2(NUM_CMDS_MAX);
    localparam int unsigned CW = $clog2(NUM_CMDS_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   rd_idx_q, rd_idx_d;   // one spare bit so the index can never wrap
    logic [CW-1:0] len_q, len_d;
    logic          load_err_q, load_err_d;
    logic [CW-1:0] len_clamped;
    logic          wr_ok;
    logic          is_last;

    osd_cmd_t      mem [NUM_CMDS_MAX];
    osd_cmd_t      rd_data_q;

    // Writes only land while idle so the replay never races a table update.
    assign wr_ok = bus.load_we && (state_q == S_IDLE) &&
                   ({1'b0, bus.load_addr} < (AW + 1)'(NUM_CMDS_MAX));

    assign len_clamped = (bus.seq_count > CW'(NUM_CMDS_MAX)) ? CW'(NUM_CMDS_MAX)
                                                             : bus.seq_count;

    // Compare rd_idx+1 against len to avoid underflow of len-1.
    assign is_last = ((rd_idx_q + (AW + 1)'(1)) == (AW + 1)'(len_q));

    // Next-state and bookkeeping for the replay sequencer.
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        len_d      = len_q;
        load_err_d = load_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d      = len_clamped;
                    rd_idx_d   = '0;
                    load_err_d = 1'b0;
                    state_d    = (len_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_SEND;
            S_SEND: begin
                if (bus.cmd_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        rd_idx_d = rd_idx_q + (AW + 1)'(1);
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A dropped write wins over the clear from a same-cycle start.
        if (bus.load_we && !wr_ok) begin
            load_err_d = 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_idx_q   <= '0;
            len_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            len_q      <= len_d;
            load_err_q <= load_err_d;
        end
    end

    // Table storage: not reset, so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Registered read port, loaded in S_FETCH and held through S_SEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (state_q == S_FETCH) begin
            rd_data_q <= mem[rd_idx_q[AW-1:0]];
        end
    end

    assign bus.busy      = (state_q == S_FETCH) || (state_q == S_SEND);
    assign bus.done      = (state_q == S_DONE);
    assign bus.load_err  = load_err_q;
    assign bus.cmd_valid = (state_q == S_SEND);
    assign bus.cmd_data  = rd_data_q;
    assign bus.cmd_last  = (state_q == S_SEND) && is_last;

endmodule
